// File: rtl/uart_arb_pkg.sv
// Shared constants for the UART transmit arbiter: FSM encodings and defaults.
package uart_arb_pkg;

  localparam int DEF_NUM_SRC = 4;
  localparam int DEF_TIMEOUT = 1024;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side handshake bundle of the transmit arbiter.
// The arbiter uses the slave view; the surrounding logic uses the master view.
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC
);
  logic [NUM_SRC-1:0]   src_valid;
  logic [8*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]   src_last;
  logic [NUM_SRC-1:0]   src_ready;
  logic [NUM_SRC-1:0]   grant;
  logic                 abort;
  logic [7:0]           tx_data;
  logic                 new_tx_data;
  logic                 tx_busy;

  modport slave (
    input  src_valid, src_data, src_last, tx_busy,
    output src_ready, grant, abort, tx_data, new_tx_data
  );

  modport master (
    output src_valid, src_data, src_last, tx_busy,
    input  src_ready, grant, abort, tx_data, new_tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first requester strictly after ptr_i, wrapping.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter  int NUM_SRC = DEF_NUM_SRC,
  localparam int PW      = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_SRC-1:0] pick_o,
  output logic [PW-1:0]      idx_o
);

  logic          found;
  logic [PW-1:0] cand;

  // Scan ptr+1 .. ptr+NUM_SRC so the last owner is considered last.
  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = PW'((int'(ptr_i) + k) % NUM_SRC);
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        pick_o[cand] = 1'b1;
        idx_o        = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of a single UART transmitter.
// A stalled owner loses its grant after TIMEOUT idle, non-busy cycles.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_SRC = DEF_NUM_SRC,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int TO_W    = $clog2(TIMEOUT),
  localparam int PW      = $clog2(NUM_SRC)
) (
  input logic                clk,
  input logic                rst,
  uart_tx_arbiter_if.slave   bus
);

  logic [1:0]         state_q,   state_d;
  logic [NUM_SRC-1:0] grant_q,   grant_d;
  logic [PW-1:0]      gidx_q,    gidx_d;
  logic [PW-1:0]      ptr_q,     ptr_d;
  logic [TO_W-1:0]    timer_q,   timer_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               new_tx_q,  new_tx_d;
  logic               abort_q,   abort_d;
  logic               last_q,    last_d;

  logic [NUM_SRC-1:0] pick;
  logic [PW-1:0]      pick_idx;
  logic               valid_g, last_g, accept, stall, timeout_hit;
  logic [7:0]         data_g;

  rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req_i  (bus.src_valid),
    .ptr_i  (ptr_q),
    .pick_o (pick),
    .idx_o  (pick_idx)
  );

  assign valid_g     = bus.src_valid[gidx_q];
  assign last_g      = bus.src_last[gidx_q];
  assign data_g      = bus.src_data[{gidx_q, 3'b000} +: 8];
  assign accept      = (state_q == ST_SEND) && valid_g && !bus.tx_busy;
  assign stall       = (state_q == ST_SEND) && !valid_g && !bus.tx_busy;
  assign timeout_hit = stall && (timer_q == TO_W'(TIMEOUT - 1));

  assign bus.src_ready   = accept ? grant_q : '0;
  assign bus.grant       = grant_q;
  assign bus.abort       = abort_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.new_tx_data = new_tx_q;

  // FSM next state: arbitrate in IDLE, move one byte per SEND/HOLD pair.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    timer_d   = timer_q;
    tx_data_d = tx_data_q;
    last_d    = last_q;
    new_tx_d  = 1'b0;
    abort_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|bus.src_valid) begin
          grant_d = pick;
          gidx_d  = pick_idx;
          timer_d = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (accept) begin
          tx_data_d = data_g;
          new_tx_d  = 1'b1;
          last_d    = last_g;
          timer_d   = '0;
          state_d   = ST_HOLD;
        end else if (timeout_hit) begin
          abort_d = 1'b1;
          grant_d = '0;
          ptr_d   = gidx_q;
          state_d = ST_IDLE;
        end else if (stall) begin
          timer_d = timer_q + TO_W'(1);
        end
      end
      ST_HOLD: begin
        // One cycle here lets tx_busy rise before the next accept decision.
        if (last_q) begin
          ptr_d   = gidx_q;
          grant_d = '0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; pointer resets to the top index so source 0 wins first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      ptr_q     <= PW'(NUM_SRC - 1);
      timer_q   <= '0;
      tx_data_q <= '0;
      new_tx_q  <= 1'b0;
      abort_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      ptr_q     <= ptr_d;
      timer_q   <= timer_d;
      tx_data_q <= tx_data_d;
      new_tx_q  <= new_tx_d;
      abort_q   <= abort_d;
      last_q    <= last_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: table of arbitration vectors plus
// hand-written multi-cycle sequences (busy pacing, timeout, busy stall, reset).
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int NS = 4;
  localparam int TO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_SRC(NS)) bus ();

  uart_tx_arbiter #(.NUM_SRC(NS), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [8:0]    sbuf [NS][64];
  int            shead[NS];
  int            stail[NS];
  logic [NS-1:0] rdy_cap;
  int            busy_len = 0;
  int            busy_cnt;
  logic          force_busy = 1'b0;
  logic [NS-1:0] log_g[$];
  logic [7:0]    log_d[$];

  typedef struct packed {
    logic [NS-1:0]   req;
    logic [2:0]      n;
    logic [3:0][1:0] ord;
  } vec_t;

  vec_t vt[8];

  // Source queues and UART busy model, updated just after each rising edge.
  initial begin
    bus.src_valid = '0;
    bus.src_data  = '0;
    bus.src_last  = '0;
    bus.tx_busy   = 1'b0;
    busy_cnt      = 0;
    rdy_cap       = '0;
    for (int i = 0; i < NS; i++) shead[i] = 0;
    forever begin
      @(negedge clk);
      rdy_cap = bus.src_ready;
      @(posedge clk);
      #1;
      if (!rst_n) busy_cnt = 0;
      else if (bus.new_tx_data) begin
        log_g.push_back(bus.grant);
        log_d.push_back(bus.tx_data);
        busy_cnt = busy_len;
      end else if (busy_cnt > 0) busy_cnt--;
      bus.tx_busy = force_busy || (busy_cnt > 0);
      for (int i = 0; i < NS; i++) begin
        if (rdy_cap[i]) shead[i]++;
        if (shead[i] < stail[i]) begin
          bus.src_valid[i]      = 1'b1;
          bus.src_data[i*8 +: 8] = sbuf[i][shead[i]][7:0];
          bus.src_last[i]       = sbuf[i][shead[i]][8];
        end else begin
          bus.src_valid[i] = 1'b0;
          bus.src_last[i]  = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mkv(logic [NS-1:0] r, int n, int o0, int o1, int o2, int o3);
    vec_t v;
    v.req    = r;
    v.n      = 3'(n);
    v.ord[0] = 2'(o0);
    v.ord[1] = 2'(o1);
    v.ord[2] = 2'(o2);
    v.ord[3] = 2'(o3);
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every wait advances through here so the handshake rules are checked each cycle.
  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      checks++;
      if (((bus.src_ready & ~bus.grant) != '0) || (bus.tx_busy && (|bus.src_ready)) ||
          ($countones(bus.grant) > 1)) begin
        errors++;
        $display("FAIL handshake: ready=%b grant=%b busy=%b", bus.src_ready, bus.grant, bus.tx_busy);
      end
    end
  endtask

  task automatic push(int s, logic [7:0] d, logic l);
    sbuf[s][stail[s]] = {l, d};
    stail[s]++;
  endtask

  task automatic wait_log(int n, int budget, string name);
    int k;
    k = 0;
    while (!(log_g.size() >= n && bus.grant == '0) && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (k >= budget) begin
      errors++;
      $display("FAIL %s: timed out with %0d bytes, expected %0d", name, log_g.size(), n);
    end
  endtask

  task automatic wait_ready(int s, int budget, string name);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!bus.src_ready[s] && k < budget);
    checks++;
    if (!bus.src_ready[s]) begin
      errors++;
      $display("FAIL %s: src_ready[%0d] never rose", name, s);
    end
  endtask

  task automatic chk_log(int idx, int src, logic [7:0] d, string name);
    logic [NS-1:0] eg;
    eg = NS'(1) << src;
    checks++;
    if (idx >= log_g.size()) begin
      errors++;
      $display("FAIL %s: entry %0d missing, have %0d", name, idx, log_g.size());
    end else if (log_g[idx] !== eg || log_d[idx] !== d) begin
      errors++;
      $display("FAIL %s[%0d]: got grant=%b data=%h expected grant=%b data=%h",
               name, idx, log_g[idx], log_d[idx], eg, d);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    force_busy = 1'b0;
    rst_n      = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int base, k, aborts;
    for (int i = 0; i < NS; i++) stail[i] = 0;

    // Reset state
    tick();
    chk("rst grant", 32'(bus.grant), 0);
    chk("rst new_tx", 32'(bus.new_tx_data), 0);
    chk("rst tx_data", 32'(bus.tx_data), 0);
    chk("rst abort", 32'(bus.abort), 0);
    rst_n = 1'b1;
    tick();
    chk("idle ready", 32'(bus.src_ready), 0);
    chk("idle grant", 32'(bus.grant), 0);

    // Table: single-byte requests, round-robin order carried across vectors.
    vt[0] = mkv(4'b0101, 2, 0, 2, 0, 0);
    vt[1] = mkv(4'b0101, 2, 0, 2, 0, 0);
    vt[2] = mkv(4'b1111, 4, 3, 0, 1, 2);
    vt[3] = mkv(4'b0110, 2, 1, 2, 0, 0);
    vt[4] = mkv(4'b1000, 1, 3, 0, 0, 0);
    vt[5] = mkv(4'b1001, 2, 0, 3, 0, 0);
    vt[6] = mkv(4'b0010, 1, 1, 0, 0, 0);
    vt[7] = mkv(4'b0011, 2, 0, 1, 0, 0);
    busy_len = 2;
    for (int v = 0; v < 8; v++) begin
      base = log_g.size();
      for (int i = 0; i < NS; i++)
        if (vt[v].req[i]) push(i, 8'(16 * v + i), 1'b1);
      wait_log(base + int'(vt[v].n), 100, "table drain");
      tick();
      chk("table count", 32'(log_g.size() - base), 32'(vt[v].n));
      for (int j = 0; j < int'(vt[v].n); j++)
        chk_log(base + j, int'(vt[v].ord[j]), 8'(16 * v + int'(vt[v].ord[j])), "table order");
    end

    // Single source, 3-byte packet paced by a long busy.
    busy_len = 11;
    base = log_g.size();
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b0);
    push(0, 8'h43, 1'b1);
    k = 0;
    do begin
      tick();
      k++;
    end while (!(bus.src_ready[0] && bus.src_data[7:0] == 8'h43) && k < 200);
    chk("abc last accept seen", 32'(bus.src_ready[0]), 1);
    tick();
    chk("abc hold grant", 32'(bus.grant), 32'h1);
    chk("abc hold pulse", 32'(bus.new_tx_data), 1);
    tick();
    chk("abc release grant", 32'(bus.grant), 0);
    for (int j = 0; j < 15; j++) tick();
    chk("abc pulse count", 32'(log_g.size() - base), 3);
    chk_log(base + 0, 0, 8'h41, "abc");
    chk_log(base + 1, 0, 8'h42, "abc");
    chk_log(base + 2, 0, 8'h43, "abc");

    // Sources 0 and 2, two rounds of 2-byte packets: order 0,2,0,2.
    do_reset();
    busy_len = 2;
    base = log_g.size();
    push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b1);
    push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b1);
    wait_log(base + 4, 200, "pair round 1");
    push(0, 8'hB0, 1'b0); push(0, 8'hB1, 1'b1);
    push(2, 8'hD0, 1'b0); push(2, 8'hD1, 1'b1);
    wait_log(base + 8, 200, "pair round 2");
    chk_log(base + 0, 0, 8'hA0, "pair");
    chk_log(base + 1, 0, 8'hA1, "pair");
    chk_log(base + 2, 2, 8'hC0, "pair");
    chk_log(base + 3, 2, 8'hC1, "pair");
    chk_log(base + 4, 0, 8'hB0, "pair");
    chk_log(base + 5, 0, 8'hB1, "pair");
    chk_log(base + 6, 2, 8'hD0, "pair");
    chk_log(base + 7, 2, 8'hD1, "pair");

    // All four requesting continuously: 0,1,2,3,0 with contiguous packets.
    do_reset();
    base = log_g.size();
    push(0, 8'h00, 1'b0); push(0, 8'h01, 1'b1);
    push(0, 8'h04, 1'b0); push(0, 8'h05, 1'b1);
    push(1, 8'h10, 1'b0); push(1, 8'h11, 1'b1);
    push(2, 8'h20, 1'b0); push(2, 8'h21, 1'b1);
    push(3, 8'h30, 1'b0); push(3, 8'h31, 1'b1);
    wait_log(base + 10, 400, "all four");
    chk_log(base + 0, 0, 8'h00, "all4");
    chk_log(base + 1, 0, 8'h01, "all4");
    chk_log(base + 2, 1, 8'h10, "all4");
    chk_log(base + 3, 1, 8'h11, "all4");
    chk_log(base + 4, 2, 8'h20, "all4");
    chk_log(base + 5, 2, 8'h21, "all4");
    chk_log(base + 6, 3, 8'h30, "all4");
    chk_log(base + 7, 3, 8'h31, "all4");
    chk_log(base + 8, 0, 8'h04, "all4");
    chk_log(base + 9, 0, 8'h05, "all4");

    // Timeout: source 1 stalls mid-packet, source 2 waiting.
    do_reset();
    busy_len = 0;
    base = log_g.size();
    push(1, 8'h55, 1'b0);
    push(2, 8'h66, 1'b1);
    wait_ready(1, 20, "timeout accept");
    k = 0;
    do begin
      tick();
      k++;
    end while (!bus.abort && k < 60);
    chk("timeout abort latency", 32'(k), 18);
    chk("timeout grant cleared", 32'(bus.grant), 0);
    tick();
    chk("abort one cycle", 32'(bus.abort), 0);
    chk("pending source granted", 32'(bus.grant), 32'h4);
    wait_log(base + 2, 40, "timeout drain");
    chk_log(base + 0, 1, 8'h55, "timeout");
    chk_log(base + 1, 2, 8'h66, "timeout");

    // Busy during a stall freezes the timer: 5 + 11 non-busy cycles to abort.
    do_reset();
    busy_len = 0;
    push(0, 8'h77, 1'b0);
    wait_ready(0, 20, "stall accept");
    for (int j = 0; j < 6; j++) tick();
    force_busy = 1'b1;
    aborts = 0;
    for (int j = 0; j < 2 * TO; j++) begin
      tick();
      if (bus.abort) aborts++;
    end
    chk("no abort while busy", 32'(aborts), 0);
    chk("grant kept while busy", 32'(bus.grant), 32'h1);
    force_busy = 1'b0;
    k = 0;
    do begin
      tick();
      k++;
    end while (!bus.abort && k < 40);
    chk("abort after busy release", 32'(k), 12);

    // Reset mid-packet clears outputs at once; source 0 wins afterwards.
    do_reset();
    busy_len = 3;
    push(3, 8'h31, 1'b0);
    push(3, 8'h32, 1'b0);
    push(3, 8'h33, 1'b1);
    k = 0;
    do begin
      tick();
      k++;
    end while (!bus.new_tx_data && k < 20);
    chk("pre-reset pulse", 32'(bus.new_tx_data), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async rst new_tx", 32'(bus.new_tx_data), 0);
    chk("async rst grant", 32'(bus.grant), 0);
    chk("async rst tx_data", 32'(bus.tx_data), 0);
    base = log_g.size();
    push(0, 8'h09, 1'b1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post-reset priority", 32'(bus.grant), 32'h1);
    wait_log(base + 3, 100, "post-reset drain");
    chk_log(base + 0, 0, 8'h09, "post-reset");
    chk_log(base + 1, 3, 8'h32, "post-reset");
    chk_log(base + 2, 3, 8'h33, "post-reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
